// File: rtl/parallel_transmitter_pkg.sv
// Shared definitions for the parallel link: FSM state encodings and sizing helpers.
// The Receiver side imports the same package so both ends agree on encodings.
package parallel_transmitter_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH     = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_SETUP    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_WAIT_REL = 3'd4
  } tx_state_t;

  // Bits needed for a counter that must reach max(a, b)
  function automatic int cnt_bits(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/parallel_transmitter_fifo.sv
// Synchronous word FIFO; read data is registered and valid the edge after rd_en.
module parallel_transmitter_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          wr_ok, rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr];
      end
      // simultaneous push and pop leaves occupancy unchanged
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/parallel_transmitter_sync.sv
// Multi-flop synchroniser for a single asynchronous level (remote ready).
module parallel_transmitter_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/parallel_transmitter.sv
// Sending side of the FPGA-to-FPGA parallel link: FIFO-buffered words driven onto
// the bus under a 4-phase valid/ready handshake with a synchronised remote ready.
module parallel_transmitter
  import parallel_transmitter_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk_tx,
  input  logic                  rst_tx,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  output logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] parallel_data_out,
  output logic                  parallel_valid_out,
  input  logic                  parallel_ready_in,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  tx_count,
  output logic                  timeout_err
);

  localparam int CW     = cnt_bits(SETUP_CYCLES, TIMEOUT_CYCLES);
  localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);

  tx_state_t             state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  valid;
  logic                  ready_sync;
  logic                  fifo_empty;
  logic                  read_en;
  logic                  setup_done;
  logic                  to_limit;
  logic                  to_last;

  parallel_transmitter_sync #(.STAGES(2)) u_ready_sync (
    .clk (clk_tx),
    .rst (rst_tx),
    .d   (parallel_ready_in),
    .q   (ready_sync)
  );

  parallel_transmitter_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_tx),
    .rst   (rst_tx),
    .wr_en (wr_en),
    .din   (data_in),
    .rd_en (read_en),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign read_en    = (state == ST_IDLE) && !fifo_empty;
  assign setup_done = (cnt == CW'(SETUP_CYCLES - 1));
  assign to_limit   = (cnt == CW'(TIMEOUT_CYCLES));
  assign to_last    = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_tx or posedge rst_tx) begin
    if (rst_tx) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      data_reg    <= '0;
      valid       <= 1'b0;
      tx_count    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          valid <= 1'b0;
          cnt   <= '0;
          if (!fifo_empty) state <= ST_FETCH;
        end
        ST_FETCH: begin
          data_reg <= fifo_dout;
          cnt      <= '0;
          state    <= ST_SETUP;
        end
        ST_SETUP: begin
          // valid may only rise once the partner has released ready
          if (setup_done) begin
            if (!ready_sync) begin
              valid <= 1'b1;
              cnt   <= '0;
              state <= ST_WAIT_ACK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (ready_sync) begin
            valid <= 1'b0;
            cnt   <= '0;
            state <= ST_WAIT_REL;
          end else if (TO_EN && !to_limit) begin
            cnt <= cnt + 1'b1;
            if (to_last) timeout_err <= 1'b1;
          end
        end
        ST_WAIT_REL: begin
          if (!ready_sync) begin
            tx_count <= tx_count + 1'b1;
            cnt      <= '0;
            state    <= ST_IDLE;
          end else if (TO_EN && !to_limit) begin
            cnt <= cnt + 1'b1;
            if (to_last) timeout_err <= 1'b1;
          end
        end
        default: begin
          valid <= 1'b0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign parallel_data_out  = data_reg;
  assign parallel_valid_out = valid;
  assign busy               = (state != ST_IDLE);

endmodule
